// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Hazard and forwarding controller for an in-order pipeline. A shift-register
//   scoreboard tracks the destination of every instruction between EX (entry 0)
//   and WB (entry STAGES-1). From it the unit derives, for the ID stage:
//   per-operand forwarding selects/data, load-use stalls, multi-cycle (mul/div)
//   stalls and flush bubbles, plus two saturating stall-cycle counters.
//
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs1/id_rs2            ID source registers, id_rs*_used: source is read
//   id_we/id_rd              ID instruction writes id_rd
//   id_is_load, id_is_mc     ID instruction is a load / multi-cycle op
//   stage_data               current result per entry, slice k = [k*XLEN +: XLEN]
//   mc_done                  multi-cycle result valid on slice 0 this cycle
//   flush                    EX redirect, the ID instruction is discarded
//   stall                    hold PC, IF/ID and ID
//   fwd_sel_a/b              0 = register file, k+1 = entry k
//   fwd_a/b                  forwarded value (0 when select is 0)
//   mc_busy                  multi-cycle op occupies entry 0
//   cnt_ld_stall/cnt_mc_stall saturating stall-cycle counters
module pipe_hazard_unit #(
  parameter int XLEN     = 32,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNTW     = 16,
  localparam int SELW    = $clog2(STAGES + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic                   id_we,
  input  logic [4:0]             id_rd,
  input  logic                   id_is_load,
  input  logic                   id_is_mc,
  input  logic [STAGES*XLEN-1:0] stage_data,
  input  logic                   mc_done,
  input  logic                   flush,
  output logic                   stall,
  output logic [SELW-1:0]        fwd_sel_a,
  output logic [SELW-1:0]        fwd_sel_b,
  output logic [XLEN-1:0]        fwd_a,
  output logic [XLEN-1:0]        fwd_b,
  output logic                   mc_busy,
  output logic [CNTW-1:0]        cnt_ld_stall,
  output logic [CNTW-1:0]        cnt_mc_stall
);

  // Scoreboard: one entry per tracked stage
  logic [STAGES-1:0] v_q, v_d;
  logic [STAGES-1:0] we_q, we_d;
  logic [STAGES-1:0] ld_q, ld_d;
  logic [STAGES-1:0] mc_q, mc_d;
  logic [4:0]        rd_q [STAGES];
  logic [4:0]        rd_d [STAGES];

  logic              mc_busy_q, mc_busy_d;
  logic [CNTW-1:0]   cnt_ld_q, cnt_ld_d;
  logic [CNTW-1:0]   cnt_mc_q, cnt_mc_d;

  logic [STAGES-1:0] ready;
  logic [9:0]        src_rs;
  logic [1:0]        src_used;
  logic [2*SELW-1:0] sel_all;
  logic [2*XLEN-1:0] fwd_all;
  logic [1:0]        haz;

  logic hold, flush_eff, hazard, issue;

  assign src_rs   = {id_rs2, id_rs1};
  assign src_used = {id_rs2_used, id_rs1_used};

  // An entry's result is usable once its producer has reached the point where
  // the value exists: loads at LOAD_LAT, mc ops once past EX or in the done cycle.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_ready
    localparam logic LD_OK = (gi >= LOAD_LAT);
    localparam logic MC_OK = (gi >= 1);
    assign ready[gi] = (~ld_q[gi] & ~mc_q[gi])
                     | (ld_q[gi] & LD_OK)
                     | (mc_q[gi] & (MC_OK | mc_done));
  end

  // Per-operand lookup: the lowest matching entry is the youngest writer.
  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    logic [STAGES-1:0] match;
    logic [SELW-1:0]   op_sel;
    logic [XLEN-1:0]   op_fwd;
    logic              hit, hit_rdy;

    always_comb begin
      for (int k = 0; k < STAGES; k++) begin
        match[k] = v_q[k] & we_q[k] & (rd_q[k] == src_rs[gi*5 +: 5])
                 & (src_rs[gi*5 +: 5] != 5'd0) & src_used[gi];
      end
    end

    always_comb begin
      op_sel  = '0;
      op_fwd  = '0;
      hit     = 1'b0;
      hit_rdy = 1'b0;
      // Scan oldest to youngest so the youngest match is the one that sticks.
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (match[k]) begin
          op_sel  = SELW'(k + 1);
          op_fwd  = stage_data[k*XLEN +: XLEN];
          hit     = 1'b1;
          hit_rdy = ready[k];
        end
      end
    end

    assign sel_all[gi*SELW +: SELW] = op_sel;
    assign fwd_all[gi*XLEN +: XLEN] = op_fwd;
    assign haz[gi]                  = hit & ~hit_rdy;
  end

  // While an mc op is held in EX a redirect cannot come from EX, so flush is ignored.
  assign hold      = mc_busy_q & ~mc_done;
  assign flush_eff = flush & ~hold;
  assign hazard    = id_valid & (haz[0] | haz[1]);
  assign stall     = (hazard | hold) & ~flush_eff;
  assign issue     = id_valid & ~stall & ~flush_eff;

  always_comb begin
    v_d  = v_q;
    we_d = we_q;
    ld_d = ld_q;
    mc_d = mc_q;
    rd_d = rd_q;
    // Entry 0 is frozen while the mc op is held; otherwise it takes ID or a bubble.
    if (!hold) begin
      v_d[0]  = issue;
      we_d[0] = id_we;
      rd_d[0] = id_rd;
      ld_d[0] = id_is_load;
      mc_d[0] = id_is_mc;
    end
    // A held entry 0 must not be duplicated downstream, so entry 1 gets a bubble.
    v_d[1]  = v_q[0] & ~hold;
    we_d[1] = we_q[0];
    rd_d[1] = rd_q[0];
    ld_d[1] = ld_q[0];
    mc_d[1] = mc_q[0];
    for (int k = 2; k < STAGES; k++) begin
      v_d[k]  = v_q[k-1];
      we_d[k] = we_q[k-1];
      rd_d[k] = rd_q[k-1];
      ld_d[k] = ld_q[k-1];
      mc_d[k] = mc_q[k-1];
    end
  end

  always_comb begin
    mc_busy_d = hold | (issue & id_is_mc);
    cnt_ld_d  = cnt_ld_q;
    cnt_mc_d  = cnt_mc_q;
    if (stall && !mc_busy_q && (cnt_ld_q != {CNTW{1'b1}})) begin
      cnt_ld_d = cnt_ld_q + CNTW'(1);
    end
    if (hold && (cnt_mc_q != {CNTW{1'b1}})) begin
      cnt_mc_d = cnt_mc_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= '0;
      we_q      <= '0;
      ld_q      <= '0;
      mc_q      <= '0;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k] <= '0;
      end
      mc_busy_q <= 1'b0;
      cnt_ld_q  <= '0;
      cnt_mc_q  <= '0;
    end else begin
      v_q       <= v_d;
      we_q      <= we_d;
      ld_q      <= ld_d;
      mc_q      <= mc_d;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k] <= rd_d[k];
      end
      mc_busy_q <= mc_busy_d;
      cnt_ld_q  <= cnt_ld_d;
      cnt_mc_q  <= cnt_mc_d;
    end
  end

  assign fwd_sel_a    = sel_all[0 +: SELW];
  assign fwd_sel_b    = sel_all[SELW +: SELW];
  assign fwd_a        = fwd_all[0 +: XLEN];
  assign fwd_b        = fwd_all[XLEN +: XLEN];
  assign mc_busy      = mc_busy_q;
  assign cnt_ld_stall = cnt_ld_q;
  assign cnt_mc_stall = cnt_mc_q;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Testbench for pipe_hazard_unit (STAGES=3, LOAD_LAT=1, CNTW=4).
// Directed vector tables, hand-written multi-cycle/reset/saturation sequences
// and a randomized run against an in-flight-instruction list model.
module tb_pipe_hazard_unit;
  localparam int XLEN     = 32;
  localparam int STAGES   = 3;
  localparam int LOAD_LAT = 1;
  localparam int CNTW     = 4;
  localparam int CMAX     = 15;
  localparam logic [31:0] S0 = 32'h0000_1234;
  localparam logic [31:0] S1 = 32'hAAAA_0001;
  localparam logic [31:0] S2 = 32'hBBBB_0002;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   id_valid, id_rs1_used, id_rs2_used, id_we, id_is_load, id_is_mc;
  logic [4:0]             id_rs1, id_rs2, id_rd;
  logic [STAGES*XLEN-1:0] stage_data;
  logic                   mc_done, flush;
  logic                   stall, mc_busy;
  logic [1:0]             fwd_sel_a, fwd_sel_b;
  logic [XLEN-1:0]        fwd_a, fwd_b;
  logic [CNTW-1:0]        cnt_ld_stall, cnt_mc_stall;

  int n_checks = 0;
  int n_err    = 0;

  pipe_hazard_unit #(.XLEN(XLEN), .STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_we(id_we), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_is_mc(id_is_mc), .stage_data(stage_data),
    .mc_done(mc_done), .flush(flush), .stall(stall), .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b), .fwd_a(fwd_a), .fwd_b(fwd_b), .mc_busy(mc_busy),
    .cnt_ld_stall(cnt_ld_stall), .cnt_mc_stall(cnt_mc_stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        valid;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, we, ld, mc, done, flush;
    logic [31:0] s0;
    logic        e_stall;
    logic [1:0]  e_sa, e_sb;
    logic        c_fa, c_fb;
    logic [31:0] e_fa, e_fb;
    logic        e_busy;
    logic [3:0]  e_cld, e_cmc;
  } vec_t;

  function automatic vec_t vin(logic valid, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                               logic u2, logic we, logic [4:0] rd, logic ld, logic mc,
                               logic done, logic fl);
    vec_t v;
    v = '{default: '0};
    v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.we = we; v.rd = rd; v.ld = ld; v.mc = mc; v.done = done; v.flush = fl;
    v.s0 = S0;
    return v;
  endfunction

  function automatic vec_t vex(vec_t vi, logic st, logic [1:0] sa, logic [1:0] sb,
                               logic cfa, logic [31:0] fa, logic cfb, logic [31:0] fb,
                               logic busy, int cld, int cmc);
    vec_t v;
    v = vi;
    v.e_stall = st; v.e_sa = sa; v.e_sb = sb; v.c_fa = cfa; v.e_fa = fa;
    v.c_fb = cfb; v.e_fb = fb; v.e_busy = busy;
    v.e_cld = 4'(cld); v.e_cmc = 4'(cmc);
    return v;
  endfunction

  function automatic int sat(int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.u1;
    id_rs2_used = v.u2; id_we = v.we; id_rd = v.rd; id_is_load = v.ld;
    id_is_mc = v.mc; mc_done = v.done; flush = v.flush;
    stage_data = {S2, S1, v.s0};
  endtask

  task automatic show(input string tag);
    $display("%s: stall=%0b sel_a=%0d sel_b=%0d fwd_a=%h fwd_b=%h busy=%0b cld=%0d cmc=%0d",
             tag, stall, fwd_sel_a, fwd_sel_b, fwd_a, fwd_b, mc_busy, cnt_ld_stall, cnt_mc_stall);
  endtask

  // Called at posedge+1; leaves at the next posedge+1.
  task automatic apply_vec(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall), 32'(v.e_stall));
    chk({tag, ".sel_a"}, 32'(fwd_sel_a), 32'(v.e_sa));
    chk({tag, ".sel_b"}, 32'(fwd_sel_b), 32'(v.e_sb));
    if (v.c_fa) chk({tag, ".fwd_a"}, fwd_a, v.e_fa);
    if (v.c_fb) chk({tag, ".fwd_b"}, fwd_b, v.e_fb);
    chk({tag, ".busy"}, 32'(mc_busy), 32'(v.e_busy));
    chk({tag, ".cnt_ld"}, 32'(cnt_ld_stall), 32'(v.e_cld));
    chk({tag, ".cnt_mc"}, 32'(cnt_mc_stall), 32'(v.e_cmc));
    show(tag);
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: list of in-flight instructions ----------
  typedef struct {
    bit         we;
    logic [4:0] rd;
    bit         ld;
    bit         mc;
    int         pos;
  } inst_t;

  inst_t fl[$];
  bit    m_busy;
  int    m_cld, m_cmc;

  task automatic model_clear();
    fl.delete();
    m_busy = 0; m_cld = 0; m_cmc = 0;
  endtask

  // Youngest in-flight writer of r; its result exists once the producer is far enough along.
  task automatic find(input logic used, input logic [4:0] r, output int sel,
                      output bit haz, output logic [31:0] d);
    int best;
    int bi;
    best = -1; bi = -1;
    if (used && r != 5'd0) begin
      foreach (fl[i]) begin
        if (fl[i].we && fl[i].rd == r && (best < 0 || fl[i].pos < best)) begin
          best = fl[i].pos; bi = i;
        end
      end
    end
    if (best < 0) begin
      sel = 0; haz = 0; d = '0;
    end else begin
      bit rdy;
      if (fl[bi].ld)      rdy = (best >= LOAD_LAT);
      else if (fl[bi].mc) rdy = (best >= 1) || (mc_done == 1'b1);
      else                rdy = 1;
      sel = best + 1; haz = !rdy; d = stage_data[best*XLEN +: XLEN];
    end
  endtask

  task automatic model_cycle(input string tag);
    int sa, sb;
    bit ha, hb, hold, feff, st, iss;
    logic [31:0] da, db;
    inst_t nq[$];
    inst_t ni;
    find(id_rs1_used, id_rs1, sa, ha, da);
    find(id_rs2_used, id_rs2, sb, hb, db);
    hold = m_busy && (mc_done == 1'b0);
    feff = (flush == 1'b1) && !hold;
    st   = (((id_valid == 1'b1) && (ha || hb)) || hold) && !feff;
    iss  = (id_valid == 1'b1) && !st && !feff;
    chk({tag, ".stall"}, 32'(stall), 32'(st));
    chk({tag, ".sel_a"}, 32'(fwd_sel_a), 32'(sa));
    chk({tag, ".sel_b"}, 32'(fwd_sel_b), 32'(sb));
    if (!ha) chk({tag, ".fwd_a"}, fwd_a, da);
    if (!hb) chk({tag, ".fwd_b"}, fwd_b, db);
    chk({tag, ".busy"}, 32'(mc_busy), 32'(m_busy));
    chk({tag, ".cnt_ld"}, 32'(cnt_ld_stall), 32'(m_cld));
    chk({tag, ".cnt_mc"}, 32'(cnt_mc_stall), 32'(m_cmc));
    // advance: everything moves one stage, except a held op stays in EX
    if (st && !m_busy) m_cld = sat(m_cld + 1);
    if (hold)          m_cmc = sat(m_cmc + 1);
    foreach (fl[i]) begin
      ni = fl[i];
      if (!hold || ni.pos > 0) ni.pos++;
      if (ni.pos < STAGES) nq.push_back(ni);
    end
    fl = nq;
    if (iss) begin
      ni.we = id_we; ni.rd = id_rd; ni.ld = id_is_load; ni.mc = id_is_mc; ni.pos = 0;
      fl.push_front(ni);
    end
    m_busy = hold || (iss && (id_is_mc == 1'b1));
  endtask

  // Reset with a pending read in ID; everything must read as zero.
  task automatic do_reset(input string tag);
    drive(vin(1, 5'd5, 1, 5'd6, 1, 1, 5'd7, 0, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".sel_a"}, 32'(fwd_sel_a), 32'd0);
    chk({tag, ".fwd_a"}, fwd_a, 32'd0);
    chk({tag, ".busy"}, 32'(mc_busy), 32'd0);
    chk({tag, ".cnt_ld"}, 32'(cnt_ld_stall), 32'd0);
    show(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  vec_t tA[17];
  vec_t tB[9];
  vec_t v;

  initial begin
    // Table A: ALU forwarding, load-use, priority, x0, flush, unused sources, invalid ID
    tA[0]  = vex(vin(1, 1, 1, 2, 1, 1, 5, 0, 0, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tA[1]  = vex(vin(1, 5, 1, 5, 1, 1, 6, 0, 0, 0, 0), 0, 1, 1, 1, S0, 1, S0, 0, 0, 0);
    tA[2]  = vex(vin(1, 0, 1, 0, 0, 1, 7, 1, 0, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tA[3]  = vex(vin(1, 7, 1, 6, 1, 1, 8, 0, 0, 0, 0), 1, 1, 2, 0, 0, 1, S1, 0, 0, 0);
    tA[4]  = vex(vin(1, 7, 1, 6, 1, 1, 8, 0, 0, 0, 0), 0, 2, 3, 1, S1, 1, S2, 0, 1, 0);
    tA[5]  = vex(vin(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    tA[6]  = vex(vin(1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    tA[7]  = vex(vin(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    tA[8]  = vex(vin(1, 3, 1, 3, 1, 0, 0, 0, 0, 0, 0), 0, 1, 1, 1, S0, 1, S0, 0, 1, 0);
    tA[9]  = vex(vin(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    tA[10] = vex(vin(1, 0, 1, 3, 1, 0, 0, 0, 0, 0, 0), 0, 0, 3, 1, 0, 1, S2, 0, 1, 0);
    tA[11] = vex(vin(1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    tA[12] = vex(vin(1, 12, 1, 0, 0, 1, 13, 0, 0, 0, 1), 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);
    tA[13] = vex(vin(1, 12, 1, 13, 1, 0, 0, 0, 0, 0, 0), 0, 2, 0, 1, S1, 1, 0, 0, 1, 0);
    tA[14] = vex(vin(1, 12, 0, 12, 1, 0, 0, 0, 0, 0, 0), 0, 0, 3, 1, 0, 1, S2, 0, 1, 0);
    tA[15] = vex(vin(1, 0, 0, 0, 0, 1, 14, 1, 0, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    tA[16] = vex(vin(0, 14, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0, 1, 0, 0, 1, 0);

    // Table B: div held 4 cycles, draining entries behind it, flush ignored while held
    tB[0] = vex(vin(1, 0, 0, 0, 0, 1, 20, 0, 0, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tB[1] = vex(vin(1, 0, 0, 0, 0, 1, 9, 0, 1, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    tB[2] = vex(vin(1, 20, 1, 9, 1, 1, 21, 0, 0, 0, 0), 1, 2, 1, 1, S1, 0, 0, 1, 0, 0);
    tB[3] = vex(vin(1, 20, 1, 9, 1, 1, 21, 0, 0, 0, 0), 1, 3, 1, 1, S2, 0, 0, 1, 0, 1);
    tB[4] = vex(vin(1, 20, 1, 9, 1, 1, 21, 0, 0, 0, 1), 1, 0, 1, 1, 0, 0, 0, 1, 0, 2);
    tB[5] = vex(vin(1, 20, 1, 9, 1, 1, 21, 0, 0, 0, 0), 1, 0, 1, 1, 0, 0, 0, 1, 0, 3);
    tB[6] = vex(vin(1, 20, 1, 9, 1, 1, 21, 0, 0, 1, 0), 0, 0, 1, 1, 0, 1, 32'hDEAD, 1, 0, 4);
    tB[6].s0 = 32'hDEAD;
    tB[7] = vex(vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0, 0, 1, 0, 1, 0, 0, 0, 4);
    tB[8] = vex(vin(1, 21, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 2, 0, 1, S1, 1, 0, 0, 0, 4);

    drive(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    do_reset("rst0");
    for (int i = 0; i < 17; i++) apply_vec(tA[i], $sformatf("A%0d", i));

    do_reset("rst1");
    for (int i = 0; i < 9; i++) apply_vec(tB[i], $sformatf("B%0d", i));

    // Reset in the middle of a held mc op
    do_reset("rst2");
    apply_vec(vex(vin(1, 0, 0, 0, 0, 1, 9, 0, 1, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), "R0");
    v = vin(1, 0, 0, 9, 1, 1, 21, 0, 0, 0, 0);
    apply_vec(vex(v, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0), "R1");
    apply_vec(vex(v, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1), "R2");
    drive(v);
    #2;
    chk("R3.pre_stall", 32'(stall), 32'd1);
    chk("R3.pre_cnt_mc", 32'(cnt_mc_stall), 32'd2);
    rst = 1'b1;
    #1;
    chk("R3.stall", 32'(stall), 32'd0);
    chk("R3.sel_b", 32'(fwd_sel_b), 32'd0);
    chk("R3.fwd_b", fwd_b, 32'd0);
    chk("R3.busy", 32'(mc_busy), 32'd0);
    chk("R3.cnt_mc", 32'(cnt_mc_stall), 32'd0);
    show("R3");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Saturation: 20 load-use pairs, then an mc op held 20 cycles
    do_reset("rst3");
    for (int i = 0; i < 20; i++) begin
      apply_vec(vex(vin(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, sat(i), 0),
                $sformatf("L%0d.lw", i));
      v = vin(1, 7, 1, 0, 0, 1, 8, 0, 0, 0, 0);
      apply_vec(vex(v, 1, 1, 0, 0, 0, 1, 0, 0, sat(i), 0), $sformatf("L%0d.st", i));
      apply_vec(vex(v, 0, 2, 0, 1, S1, 1, 0, 0, sat(i + 1), 0), $sformatf("L%0d.go", i));
    end
    apply_vec(vex(vin(1, 0, 0, 0, 0, 1, 9, 0, 1, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, CMAX, 0), "M.div");
    for (int j = 0; j < 20; j++) begin
      apply_vec(vex(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 1, 0, 1, 0, 1, CMAX, sat(j)),
                $sformatf("M%0d", j));
    end
    apply_vec(vex(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 0, 0, 1, 0, 1, 0, 1, CMAX, CMAX), "M.done");
    apply_vec(vex(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 0, 1, 0, 0, CMAX, CMAX), "M.idle");

    // Randomized run against the model
    do_reset("rst4");
    for (int i = 0; i < 300; i++) begin
      id_valid    = ($urandom_range(0, 7) != 0);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom_range(0, 1));
      id_rs2_used = 1'($urandom_range(0, 1));
      id_we       = ($urandom_range(0, 3) != 0);
      id_rd       = 5'($urandom_range(0, 3));
      id_is_load  = ($urandom_range(0, 3) == 0);
      id_is_mc    = !id_is_load && ($urandom_range(0, 7) == 0);
      mc_done     = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      stage_data  = {$urandom, $urandom, $urandom};
      @(negedge clk);
      model_cycle($sformatf("X%0d", i));
      show($sformatf("X%0d", i));
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It tracks the destination register of every instruction in flight between EX and the last write-back stage in a shift-register scoreboard. From that it produces, for the ID stage, per-operand forwarding selects and data, load-use stalls, multi-cycle-unit stalls and branch-flush bubbles. It generalises the fixed two-stage forwarding and exception control to `STAGES` tracked stages, a configurable load latency, a held multi-cycle (mul/div) slot, and saturating stall counters.

## Interface
- `XLEN`, 32: data width.
- `STAGES`, 3: tracked stages after ID; entry 0 is EX, entry `STAGES-1` is WB. Minimum 2.
- `LOAD_LAT`, 1: entry index at which load data first becomes valid; 1 means MEM output.
- `CNTW`, 16: stall counter width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2` in 5 each: ID source registers.
- `id_rs1_used`, `id_rs2_used` in 1 each: the source is read.
- `id_we` in 1: ID instruction writes `id_rd`.
- `id_rd` in 5: ID destination register.
- `id_is_load` in 1: ID instruction is a load.
- `id_is_mc` in 1: ID instruction is multi-cycle (mul/div).
- `stage_data` in `STAGES*XLEN`: current result at each entry; slice k is `[k*XLEN +: XLEN]`.
- `mc_done` in 1: one-cycle pulse; the multi-cycle result is valid on `stage_data` slice 0 in this cycle.
- `flush` in 1: EX redirect; the ID instruction is discarded.
- `stall` out 1: hold PC, IF/ID and ID.
- `fwd_sel_a`, `fwd_sel_b` out `$clog2(STAGES+1)` each: 0 means register file; k+1 means entry k.
- `fwd_a`, `fwd_b` out `XLEN` each: forwarded value; 0 when the select is 0.
- `mc_busy` out 1: the multi-cycle op occupies entry 0.
- `cnt_ld_stall`, `cnt_mc_stall` out `CNTW` each: saturating stall-cycle counters.

## Operation
- Scoreboard entry k holds {v, we, rd, load, mc}. An entry matches source r when v & we & rd==r & r!=0.
- Entry k is ready when it is not a load and not an mc, or load & k>=LOAD_LAT, or mc & k>=1, or mc & k==0 & mc_done.
- Per operand, only if the source is used: pick the lowest-k matching entry (youngest wins).
  - Ready entry: select = k+1, data = slice k.
  - Not-ready entry: hazard. Select reports k+1; data is don't-care.
  - No match: select 0, data 0.
- `stall` = id_valid & (hazard_a | hazard_b) | (mc_busy & ~mc_done). `flush` forces `stall` to 0.
- Issue = id_valid & ~stall & ~flush.
- Shift on each clock when mc_busy is clear, or in the mc_done cycle:
  - Entry 0 takes the ID fields if issuing, otherwise a bubble (v=0).
  - Entry k takes entry k-1.
- Hold while mc_busy & ~mc_done: entry 0 is frozen, entry 1 takes a bubble, entries k>=2 shift normally.
- mc_busy is set on the clock that issues an id_is_mc instruction. It clears on the clock where mc_done=1. A mc_done without mc_busy is ignored.
- `flush` while mc_busy & ~mc_done is ignored.
- Counters increment by 1 per clock and saturate at all-ones, never wrapping:
  - `cnt_ld_stall` counts cycles with a hazard-driven stall and mc_busy clear.
  - `cnt_mc_stall` counts cycles with mc_busy & ~mc_done.
- On `rst`: all entries v=0, mc_busy=0, counters 0. Consequently `stall`=0, all selects 0 and `fwd_a`/`fwd_b`=0. Reset mid-mc discards the op.

## Timing
- Forwarding and stall outputs are combinational from scoreboard state plus ID inputs, for use in the same cycle.
- An instruction issued at edge N is in entry k during cycles N+1+k (absent mc holds) and leaves after entry `STAGES-1`.
- Load-use penalty is LOAD_LAT cycles for an immediately dependent instruction; 0 for non-loads.
- A multi-cycle op stalls ID from the cycle after issue until mc_done inclusive-exclusive: a dependent instruction forwards from slice 0 in the mc_done cycle.
- Register x0 never matches.

## Test plan
- Back-to-back ALU dependency: issue add x5, then ID add x6,x5,x5 with slice0=0x1234. Required: sel_a=sel_b=1, fwd_a=fwd_b=0x1234, stall=0.
- Load-use, LOAD_LAT=1: lw x7, then ID reads x7. Required: stall=1 for exactly 1 cycle, then sel_a=2 with fwd_a equal to slice1. cnt_ld_stall=1.
- Priority and x0: two in-flight writers to x3, in entries 0 and 2. Required: sel=1. An in-flight writer to x0 is read as rs1=x0: required sel=0, fwd=0.
- Multi-cycle: issue div x9; mc_done after 5 cycles with slice0=0xDEAD; dependent in ID. Required: stall high for 4 cycles, forwarding 0xDEAD in the mc_done cycle, mc_busy falls at that edge, cnt_mc_stall=4. Entries 1..STAGES-1 must be bubbles while held.
- Flush: flush=1 with a load-use hazard present. Required: stall=0, entry 0 becomes a bubble next cycle, and no ID-stage forward from it.
- Reset and saturation: CNTW=4, hold a hazard 20 cycles. Required: counter sticks at 0xF. Assert rst mid-mc: all outputs 0 immediately, mc_busy=0.
